// File: rtl/stream_blk_sched.sv
// Write/read block sequencer for the per-channel stream buffer (mem_streams).
// Optional partial-block watchdog: define STREAM_BLK_SCHED_TIMEOUT_EN (adds TIMEOUT and o_timeout).
module stream_blk_sched #(
    parameter int unsigned BLOCK_LEN  = 64,
    parameter int unsigned MAX_BLOCKS = 4,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned GAP_CYCLES = 2
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT    = 1024
`endif
) (
    input  logic                               i_clk,
    input  logic                               i_reset,
    input  logic                               i_in_vld,
    input  logic                               i_in_sop,
    output logic                               o_in_rdy,
    output logic                               o_wr_wen,
    output logic [ADDR_WIDTH-1:0]              o_wr_addr,
    input  logic                               i_out_rdy,
    output logic                               o_rd_ren,
    output logic                               o_rvalid,
    input  logic                               i_tvalid,
    output logic                               o_blk_start,
    output logic                               o_blk_done,
    output logic [$clog2(MAX_BLOCKS+1)-1:0]    o_blk_cnt,
    output logic                               o_sop_err,
    output logic                               o_busy
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
    ,
    output logic                               o_timeout
`endif
);

    localparam int unsigned WCNT_W = $clog2(BLOCK_LEN);
    localparam int unsigned CNT_W  = $clog2(MAX_BLOCKS + 1);
    localparam int unsigned GCNT_W = $clog2(GAP_CYCLES) + 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(BLOCK_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BLOCKS);
    localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
`endif

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_GAP} state_e;

    state_e                state_q, state_d;
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
    logic [WCNT_W-1:0]     rcnt_q, rcnt_d;
    logic [GCNT_W-1:0]     gcnt_q, gcnt_d;
    logic [WCNT_W-1:0]     tcnt_q, tcnt_d;
    logic                  tarm_q, tarm_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic                  wr_wen_q, wr_wen_d;
    logic                  in_rdy_q, in_rdy_d;
    logic [CNT_W-1:0]      blk_cnt_q, blk_cnt_d;
    logic                  sop_err_q, sop_err_d;
    logic                  rd_ren_q, rd_ren_d;
    logic                  rvalid_q, rvalid_d;
    logic                  blk_start_q, blk_start_d;
    logic                  blk_done_q, blk_done_d;
    logic                  busy_q, busy_d;
    logic                  acc_c, blk_inc_c, blk_dec_c;
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
    logic [WD_W-1:0]       wd_q, wd_d;
    logic                  timeout_q, timeout_d;
`endif

    // Next-state: write counters, block accounting, read FSM, done tracking.
    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        gcnt_d     = gcnt_q;
        tcnt_d     = tcnt_q;
        tarm_d     = tarm_q;
        waddr_d    = waddr_q;
        wr_addr_d  = wr_addr_q;
        sop_err_d  = sop_err_q;
        blk_dec_c  = 1'b0;
        blk_done_d = 1'b0;
        acc_c      = i_in_vld & in_rdy_q;
        blk_inc_c  = acc_c && (wcnt_q == WCNT_LAST);
        wr_wen_d   = acc_c;

        if (acc_c) begin
            wr_addr_d = waddr_q;
            waddr_d   = waddr_q + ADDR_WIDTH'(1);
            wcnt_d    = blk_inc_c ? '0 : wcnt_q + WCNT_W'(1);
            // Framing errors are flagged but the word is kept in sequence.
            if ((wcnt_q == '0) != i_in_sop) sop_err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if ((blk_cnt_q != '0) && i_out_rdy) begin
                    state_d   = ST_RD;
                    rcnt_d    = '0;
                    blk_dec_c = 1'b1;
                end
            end
            ST_RD: begin
                rcnt_d = rcnt_q + WCNT_W'(1);
                if (rcnt_q == WCNT_LAST) begin
                    state_d = ST_GAP;
                    gcnt_d  = '0;
                end
            end
            ST_GAP: begin
                gcnt_d = gcnt_q + GCNT_W'(1);
                if (gcnt_q == GCNT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        blk_cnt_d = blk_cnt_q + CNT_W'(blk_inc_c) - CNT_W'(blk_dec_c);
        in_rdy_d  = !((blk_cnt_d == CNT_MAX) && (wcnt_d == '0));

        // Count buffer output words from the first burst cycle onward.
        if (blk_dec_c) begin
            tcnt_d = '0;
            tarm_d = 1'b1;
        end else if (tarm_q && i_tvalid) begin
            if (tcnt_q == WCNT_LAST) begin
                blk_done_d = 1'b1;
                tarm_d     = 1'b0;
                tcnt_d     = '0;
            end else begin
                tcnt_d = tcnt_q + WCNT_W'(1);
            end
        end

        blk_start_d = blk_dec_c;
        rd_ren_d    = (state_d == ST_RD);
        rvalid_d    = (state_d == ST_RD) || (state_q == ST_RD);
        busy_d      = (state_d != ST_IDLE);

`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
        wd_d      = wd_q;
        timeout_d = 1'b0;
        if (acc_c) begin
            wd_d = '0;
        end else if (wcnt_q != '0) begin
            if (wd_q == WD_LAST) begin
                wd_d      = '0;
                timeout_d = 1'b1;
                sop_err_d = 1'b1;
            end else begin
                wd_d = wd_q + WD_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            gcnt_q      <= '0;
            tcnt_q      <= '0;
            tarm_q      <= 1'b0;
            waddr_q     <= '0;
            wr_addr_q   <= '0;
            wr_wen_q    <= 1'b0;
            in_rdy_q    <= 1'b1;
            blk_cnt_q   <= '0;
            sop_err_q   <= 1'b0;
            rd_ren_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            blk_start_q <= 1'b0;
            blk_done_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
            wd_q        <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            gcnt_q      <= gcnt_d;
            tcnt_q      <= tcnt_d;
            tarm_q      <= tarm_d;
            waddr_q     <= waddr_d;
            wr_addr_q   <= wr_addr_d;
            wr_wen_q    <= wr_wen_d;
            in_rdy_q    <= in_rdy_d;
            blk_cnt_q   <= blk_cnt_d;
            sop_err_q   <= sop_err_d;
            rd_ren_q    <= rd_ren_d;
            rvalid_q    <= rvalid_d;
            blk_start_q <= blk_start_d;
            blk_done_q  <= blk_done_d;
            busy_q      <= busy_d;
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign o_in_rdy    = in_rdy_q;
    assign o_wr_wen    = wr_wen_q;
    assign o_wr_addr   = wr_addr_q;
    assign o_rd_ren    = rd_ren_q;
    assign o_rvalid    = rvalid_q;
    assign o_blk_start = blk_start_q;
    assign o_blk_done  = blk_done_q;
    assign o_blk_cnt   = blk_cnt_q;
    assign o_sop_err   = sop_err_q;
    assign o_busy      = busy_q;
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
    assign o_timeout   = timeout_q;
`endif

endmodule

// File: tb/tb_stream_blk_sched.sv
// Scoreboard bench for stream_blk_sched: driver queues expected writes/blocks, monitor checks them.
module tb_stream_blk_sched;

    localparam int unsigned BL  = 64;
    localparam int unsigned MB  = 4;
    localparam int unsigned AW  = 11;
    localparam int unsigned GAP = 2;

    logic          i_clk, i_reset, i_in_vld, i_in_sop, i_out_rdy, i_tvalid;
    logic          o_in_rdy, o_wr_wen, o_rd_ren, o_rvalid, o_blk_start, o_blk_done, o_sop_err, o_busy;
    logic [AW-1:0] o_wr_addr;
    logic [2:0]    o_blk_cnt;
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
    logic          o_timeout;
`endif

    stream_blk_sched #(
        .BLOCK_LEN (BL),
        .MAX_BLOCKS(MB),
        .ADDR_WIDTH(AW),
        .GAP_CYCLES(GAP)
    ) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_in_vld   (i_in_vld),
        .i_in_sop   (i_in_sop),
        .o_in_rdy   (o_in_rdy),
        .o_wr_wen   (o_wr_wen),
        .o_wr_addr  (o_wr_addr),
        .i_out_rdy  (i_out_rdy),
        .o_rd_ren   (o_rd_ren),
        .o_rvalid   (o_rvalid),
        .i_tvalid   (i_tvalid),
        .o_blk_start(o_blk_start),
        .o_blk_done (o_blk_done),
        .o_blk_cnt  (o_blk_cnt),
        .o_sop_err  (o_sop_err),
        .o_busy     (o_busy)
`ifdef STREAM_BLK_SCHED_TIMEOUT_EN
        ,
        .o_timeout  (o_timeout)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int exp_addr = 0;
    int wc      = 0;
    int blk_id  = 0;
    int wq[$];
    int cq[$];
    int bq[$];
    int last_gap = 0;
    int ndone   = 0;
    int nwraps  = 0;
    logic ren_n = 1'b0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        forever begin
            @(posedge i_clk);
            cyc = cyc + 1;
        end
    end

    // Buffer model: output valid one cycle after each read enable.
    initial begin
        i_tvalid = 1'b0;
        forever begin
            @(negedge i_clk);
            ren_n = o_rd_ren;
            @(posedge i_clk);
            #1;
            i_tvalid = ren_n;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_word(input logic sop);
        int w = 0;
        i_in_vld = 1'b1;
        i_in_sop = sop;
        while (o_in_rdy !== 1'b1 && w < 2000) begin
            tick();
            w++;
        end
        if (w >= 2000) check("in_rdy_wait", {31'd0, o_in_rdy}, 1);
        wq.push_back(exp_addr);
        cq.push_back(cyc);
        exp_addr = (exp_addr + 1) % (1 << AW);
        if (wc == int'(BL) - 1) begin
            wc = 0;
            bq.push_back(blk_id);
            blk_id++;
        end else begin
            wc++;
        end
        tick();
        i_in_vld = 1'b0;
        i_in_sop = 1'b0;
    endtask

    task automatic write_words(input int n, input int bad);
        for (int i = 0; i < n; i++) send_word((wc == 0) || (i == bad));
    endtask

    task automatic wait_start(input string nm);
        int w = 0;
        do begin
            tick();
            w++;
        end while (o_blk_start !== 1'b1 && w < 500);
        if (o_blk_start !== 1'b1) check(nm, {31'd0, o_blk_start}, 1);
    endtask

    task automatic wait_idle(input string nm);
        int w = 0;
        while (!(o_busy === 1'b0 && o_blk_cnt === 3'd0) && w < 3000) begin
            tick();
            w++;
        end
        if (w >= 3000) check(nm, {31'd0, o_busy}, 0);
    endtask

    // Monitor: pops expected writes and blocks, checks burst shape and done timing.
    initial begin
        logic prev_ren, rv_tail, tarm, done_due, exp_done;
        int ren_run, low_run, tcnt, a, c, prev_addr;
        prev_ren = 1'b0; rv_tail = 1'b0; tarm = 1'b0; done_due = 1'b0;
        ren_run = 0; low_run = 1000; tcnt = 0; prev_addr = 0;
        forever begin
            @(negedge i_clk);
            if (i_reset === 1'b1) begin
                wq.delete(); cq.delete(); bq.delete();
                prev_ren = 1'b0; rv_tail = 1'b0; tarm = 1'b0; done_due = 1'b0;
                ren_run = 0; low_run = 1000; tcnt = 0; prev_addr = 0;
                continue;
            end
            if (o_wr_wen === 1'b1) begin
                if (wq.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    a = wq.pop_front();
                    c = cq.pop_front();
                    check("wr_addr", 32'(o_wr_addr), a);
                    check("wr_lag", cyc - c, 1);
                    if (prev_addr == 2047 && int'(o_wr_addr) == 0) nwraps++;
                    prev_addr = int'(o_wr_addr);
                end
            end else if (cq.size() > 0 && cyc > cq[0] + 1) begin
                check("wr_missing", 0, 1);
                void'(wq.pop_front());
                void'(cq.pop_front());
            end
            if (o_blk_start === 1'b1) begin
                check("start_has_block", {31'd0, bq.size() > 0}, 1);
                if (bq.size() > 0) void'(bq.pop_front());
                check("start_ren", {31'd0, o_rd_ren}, 1);
                last_gap = low_run;
                tcnt = 0;
                tarm = 1'b1;
                ren_run = 0;
            end
            if (o_rd_ren === 1'b1) begin
                ren_run++;
                low_run = 0;
            end else begin
                low_run++;
                if (prev_ren) begin
                    check("burst_len", ren_run, BL);
                    check("rvalid_tail", {31'd0, o_rvalid}, 1);
                    rv_tail = 1'b1;
                    ren_run = 0;
                end else if (rv_tail) begin
                    check("rvalid_drop", {31'd0, o_rvalid}, 0);
                    rv_tail = 1'b0;
                end
            end
            prev_ren = (o_rd_ren === 1'b1);
            exp_done = done_due;
            done_due = 1'b0;
            if (o_blk_done === 1'b1 || exp_done) begin
                check("blk_done", {31'd0, o_blk_done}, {31'd0, exp_done});
                if (o_blk_done === 1'b1) ndone++;
            end
            if (tarm && i_tvalid === 1'b1) begin
                tcnt++;
                if (tcnt == int'(BL)) begin
                    done_due = 1'b1;
                    tarm = 1'b0;
                end
            end
        end
    end

    initial begin
        i_reset = 1'b1; i_in_vld = 1'b0; i_in_sop = 1'b0; i_out_rdy = 1'b0;
        repeat (3) tick();
        check("rst_in_rdy", {31'd0, o_in_rdy}, 1);
        check("rst_wr_wen", {31'd0, o_wr_wen}, 0);
        check("rst_wr_addr", 32'(o_wr_addr), 0);
        check("rst_rd_ren", {31'd0, o_rd_ren}, 0);
        check("rst_rvalid", {31'd0, o_rvalid}, 0);
        check("rst_blk_cnt", 32'(o_blk_cnt), 0);
        check("rst_sop_err", {31'd0, o_sop_err}, 0);
        check("rst_busy", {31'd0, o_busy}, 0);
        i_reset = 1'b0;
        tick();

        // One block, then one burst.
        write_words(BL, -1);
        check("t1_blk_cnt", 32'(o_blk_cnt), 1);
        check("t1_last_addr", 32'(o_wr_addr), 63);
        i_out_rdy = 1'b1;
        wait_start("t1_start");
        check("t1_cnt_at_start", 32'(o_blk_cnt), 0);
        check("t1_busy", {31'd0, o_busy}, 1);
        i_out_rdy = 1'b0;
        wait_idle("t1_idle");
        check("t1_ndone", ndone, 1);

        // Fill to MAX_BLOCKS, backpressure, then drain.
        write_words(4 * BL, -1);
        check("t2_rdy_low", {31'd0, o_in_rdy}, 0);
        check("t2_blk_cnt", 32'(o_blk_cnt), 4);
        repeat (5) tick();
        check("t2_rdy_held", {31'd0, o_in_rdy}, 0);
        i_out_rdy = 1'b1;
        wait_start("t2_start");
        check("t2_rdy_back", {31'd0, o_in_rdy}, 1);
        check("t2_cnt_at_start", 32'(o_blk_cnt), 3);
        wait_idle("t2_idle");
        check("t2_ndone", ndone, 5);
        i_out_rdy = 1'b0;

        // Block completes in the same cycle a burst starts.
        write_words(2 * BL + BL - 1, -1);
        check("t3_cnt_pre", 32'(o_blk_cnt), 2);
        i_out_rdy = 1'b1;
        send_word(1'b0);
        check("t3_start", {31'd0, o_blk_start}, 1);
        check("t3_cnt_same", 32'(o_blk_cnt), 2);
        wait_start("t3_second_start");
        tick();
        check("t3_gap", last_gap, 3);
        wait_idle("t3_idle");
        check("t3_ndone", ndone, 8);

        // 33 blocks while draining: address wraps 2047 -> 0.
        write_words(33 * BL, -1);
        wait_idle("t4_idle");
        check("t4_wraps", nwraps, 1);
        check("t4_last_addr", 32'(o_wr_addr), 575);
        check("t4_sop_err", {31'd0, o_sop_err}, 0);
        check("t4_ndone", ndone, 41);
        i_out_rdy = 1'b0;

        // Stray sop on word 10: sticky error, block still completes at 64.
        write_words(BL - 1, 10);
        check("t5_sop_err", {31'd0, o_sop_err}, 1);
        check("t5_cnt_63", 32'(o_blk_cnt), 0);
        send_word(1'b0);
        check("t5_cnt_64", 32'(o_blk_cnt), 1);
        repeat (3) tick();
        check("t5_sop_sticky", {31'd0, o_sop_err}, 1);

        // Reset mid-burst: burst aborted, no done pulse.
        i_out_rdy = 1'b1;
        wait_start("t6_start");
        repeat (10) tick();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        i_out_rdy = 1'b0;
        exp_addr = 0;
        wc = 0;
        check("t6_rd_ren", {31'd0, o_rd_ren}, 0);
        check("t6_busy", {31'd0, o_busy}, 0);
        check("t6_sop_err", {31'd0, o_sop_err}, 0);
        check("t6_in_rdy", {31'd0, o_in_rdy}, 1);
        repeat (80) tick();
        check("t6_ndone", ndone, 41);
        write_words(BL, -1);
        check("t6_addr", 32'(o_wr_addr), 63);
        check("t6_blk_cnt", 32'(o_blk_cnt), 1);
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
